// File: rtl/save_point_mgr.sv
// Save-point manager: draws save sprites, detects a save request near a point,
// latches the active point, pulses a commit strobe and blinks the saved sprite.
//
// state     | meaning
// ----------+---------------------------------------------------------
// ST_IDLE   | waiting for a save-key edge
// ST_SCAN   | testing one save point per cycle against the kid position
// ST_COMMIT | one-cycle commit: latch active point, pulse, reload flash
module save_point_mgr #(
    parameter int          NUM_SAVES    = 4,
    parameter int          SPR_W        = 20,
    parameter int          SPR_H        = 20,
    parameter int          RADIUS       = 40,
    parameter logic [7:0]  KEY_SAVE     = 8'd22,
    parameter int          FLASH_FRAMES = 30,
    parameter int          COLOR_W      = 3,
    localparam int         AW           = $clog2(SPR_W * SPR_H),
    localparam int         IW           = (NUM_SAVES > 1) ? $clog2(NUM_SAVES) : 1
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic                    frame_tick,
    input  logic                    save_exist,
    input  logic [9:0]              DrawX,
    input  logic [9:0]              DrawY,
    input  logic [9:0]              kid_x,
    input  logic [9:0]              kid_y,
    input  logic [7:0]              keycode,
    input  logic [NUM_SAVES*10-1:0] save_x_tbl,
    input  logic [NUM_SAVES*10-1:0] save_y_tbl,
    output logic [AW-1:0]           rom_addr,
    output logic                    rom_sel,
    input  logic [COLOR_W-1:0]      rom_data,
    output logic                    is_save,
    output logic [COLOR_W-1:0]      save_data,
    output logic [IW-1:0]           active_idx,
    output logic                    active_valid,
    output logic                    save_pulse
);

    localparam int             FW_RAW     = $clog2(FLASH_FRAMES + 1);
    localparam int             FW         = (FW_RAW < 3) ? 3 : FW_RAW;
    localparam logic [21:0]    R2         = 22'(RADIUS * RADIUS);
    localparam logic [FW-1:0]  FLASH_LOAD = FW'(FLASH_FRAMES);
    localparam logic [IW-1:0]  LAST_IDX   = IW'(NUM_SAVES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCAN   = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [IW-1:0]  scan_idx_q, scan_idx_d;
    logic [IW-1:0]  match_idx_q, match_idx_d;
    logic           matched_q, matched_d;
    logic [IW-1:0]  active_idx_q, active_idx_d;
    logic           active_valid_q, active_valid_d;
    logic [FW-1:0]  flash_cnt_q, flash_cnt_d;
    logic           key_q, key_hit, req;

    logic [9:0]     sx [NUM_SAVES];
    logic [9:0]     sy [NUM_SAVES];

    for (genvar g = 0; g < NUM_SAVES; g++) begin : g_tbl
        assign sx[g] = save_x_tbl[10*g +: 10];
        assign sy[g] = save_y_tbl[10*g +: 10];
    end

    assign key_hit = (keycode == KEY_SAVE);
    assign req     = save_exist & key_hit & ~key_q;

    // Distance test for the point currently under scan
    logic [10:0] dx, dy, adx, ady;
    logic [21:0] dist2;
    logic        scan_hit;

    always_comb begin
        dx       = {1'b0, kid_x} - {1'b0, sx[scan_idx_q]};
        dy       = {1'b0, kid_y} - {1'b0, sy[scan_idx_q]};
        adx      = dx[10] ? (~dx + 11'd1) : dx;
        ady      = dy[10] ? (~dy + 11'd1) : dy;
        dist2    = 22'(adx) * 22'(adx) + 22'(ady) * 22'(ady);
        scan_hit = (dist2 <= R2);
    end

    always_comb begin
        state_d        = state_q;
        scan_idx_d     = scan_idx_q;
        match_idx_d    = match_idx_q;
        matched_d      = matched_q;
        active_idx_d   = active_idx_q;
        active_valid_d = active_valid_q;
        save_pulse     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    state_d     = ST_SCAN;
                    scan_idx_d  = '0;
                    match_idx_d = '0;
                    matched_d   = 1'b0;
                end
            end
            ST_SCAN: begin
                if (scan_hit && !matched_q) begin
                    matched_d   = 1'b1;
                    match_idx_d = scan_idx_q;
                end
                if (scan_idx_q == LAST_IDX) begin
                    state_d = matched_d ? ST_COMMIT : ST_IDLE;
                end else begin
                    scan_idx_d = scan_idx_q + IW'(1);
                end
            end
            ST_COMMIT: begin
                save_pulse     = 1'b1;
                active_idx_d   = match_idx_q;
                active_valid_d = 1'b1;
                state_d        = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A commit reload takes priority over a coincident frame tick
    always_comb begin
        flash_cnt_d = flash_cnt_q;
        if (state_q == ST_COMMIT) begin
            flash_cnt_d = FLASH_LOAD;
        end else if (frame_tick && (flash_cnt_q != '0)) begin
            flash_cnt_d = flash_cnt_q - FW'(1);
        end
    end

    // Pixel stage 0: box test per point, lowest index wins
    logic signed [11:0] px_s, py_s, l_e, r_e, t_e, b_e;
    logic               any_hit, pix_hit, sel0;
    logic [IW-1:0]      hit_idx;
    logic [11:0]        col, row;
    logic [AW-1:0]      addr0;

    always_comb begin
        px_s    = {2'b00, DrawX};
        py_s    = {2'b00, DrawY};
        l_e     = '0;
        r_e     = '0;
        t_e     = '0;
        b_e     = '0;
        any_hit = 1'b0;
        hit_idx = '0;
        col     = '0;
        row     = '0;
        for (int i = 0; i < NUM_SAVES; i++) begin
            l_e = {2'b00, sx[i]} - 12'(SPR_W / 2);
            t_e = {2'b00, sy[i]} - 12'(SPR_H / 2);
            r_e = l_e + 12'(SPR_W - 1);
            b_e = t_e + 12'(SPR_H - 1);
            if (l_e[11]) l_e = '0;
            if (t_e[11]) t_e = '0;
            if (!any_hit && (px_s >= l_e) && (px_s <= r_e) && (py_s >= t_e) && (py_s <= b_e)) begin
                any_hit = 1'b1;
                hit_idx = IW'(i);
                col     = px_s - l_e;
                row     = py_s - t_e;
            end
        end
        pix_hit = save_exist & any_hit;
        addr0   = AW'(int'(row) * SPR_W + int'(col));
        sel0    = active_valid_q && (hit_idx == active_idx_q)
                  && ((flash_cnt_q == '0) || !flash_cnt_q[2]);
    end

    logic          hit1_q, hit2_q;
    logic [AW-1:0] rom_addr_q;
    logic          rom_sel_q;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q        <= ST_IDLE;
            scan_idx_q     <= '0;
            match_idx_q    <= '0;
            matched_q      <= 1'b0;
            active_idx_q   <= '0;
            active_valid_q <= 1'b0;
            flash_cnt_q    <= '0;
            key_q          <= 1'b0;
            hit1_q         <= 1'b0;
            hit2_q         <= 1'b0;
            rom_addr_q     <= '0;
            rom_sel_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            scan_idx_q     <= scan_idx_d;
            match_idx_q    <= match_idx_d;
            matched_q      <= matched_d;
            active_idx_q   <= active_idx_d;
            active_valid_q <= active_valid_d;
            flash_cnt_q    <= flash_cnt_d;
            key_q          <= key_hit;
            hit1_q         <= pix_hit;
            hit2_q         <= hit1_q;
            rom_addr_q     <= pix_hit ? addr0 : '0;
            rom_sel_q      <= pix_hit & sel0;
        end
    end

    // rom_data is already registered by the ROM, aligned with hit2_q
    assign rom_addr     = rom_addr_q;
    assign rom_sel      = rom_sel_q;
    assign is_save      = hit2_q;
    assign save_data    = hit2_q ? rom_data : '0;
    assign active_idx   = active_idx_q;
    assign active_valid = active_valid_q;

endmodule

// File: doc/save_point_mgr.md
Name: save_point_mgr

Overview:
Parametrised save-point manager for the game display path. It draws NUM_SAVES save-point sprites at table-driven positions and detects a save request when the kid is inside RADIUS of a point and the save key is pressed. It latches the active (last used) save point, emits a one-cycle commit pulse to the game-state logic, and blinks the "saved" sprite for FLASH_FRAMES frames. Pixel output is pipelined against an external synchronous sprite ROM; the block sits beside the kid and background renderers and feeds the colour mux.

Parameters:
NUM_SAVES, 4, number of save points (1..8)
SPR_W, 20, sprite width in pixels
SPR_H, 20, sprite height in pixels
RADIUS, 40, activation radius in pixels (Euclidean, inclusive)
KEY_SAVE, 8'd22, keycode that requests a save
FLASH_FRAMES, 30, blink duration after a commit, in frames
COLOR_W, 3, palette index width

Ports:
Clk  in  1  system clock
Reset  in  1  synchronous, active-high reset
frame_tick  in  1  one-cycle pulse per frame (vsync)
save_exist  in  1  save points enabled in the current room
DrawX, DrawY  in  10 each  current pixel coordinate
kid_x, kid_y  in  10 each  kid centre
keycode  in  8  current key
save_x_tbl, save_y_tbl  in  NUM_SAVES*10 each  point centres; entry i at bits [10i+9:10i]
rom_addr  out  $clog2(SPR_W*SPR_H)  sprite ROM address (registered)
rom_sel  out  1  0 = idle image, 1 = saved image (registered)
rom_data  in  COLOR_W  ROM data, valid one cycle after rom_addr/rom_sel
is_save  out  1  current pixel belongs to a save sprite
save_data  out  COLOR_W  palette index, 0 when is_save = 0
active_idx  out  $clog2(NUM_SAVES) (min 1)  last committed save point
active_valid  out  1  a save has been committed since reset
save_pulse  out  1  one-cycle commit strobe

Behaviour:
- Reset (synchronous): FSM to IDLE; is_save, save_data, rom_addr, rom_sel, active_idx, active_valid, save_pulse, flash_cnt, and key_q all 0. A reset during SCAN aborts the scan with no pulse.
- Key edge: req = save_exist & (keycode==KEY_SAVE) & ~key_q; key_q registers (keycode==KEY_SAVE) every cycle. A held key produces exactly one req.
- FSM IDLE: on req, go to SCAN, i=0, match=0.
- FSM SCAN: one point per cycle. dx = kid_x - sx[i] and dy = kid_y - sy[i] as 11-bit signed values. dist2 = dx*dx + dy*dy, 22-bit unsigned. Hit when dist2 <= RADIUS*RADIUS. The first hit (lowest i) is latched; later hits are ignored. After i = NUM_SAVES-1, go to COMMIT if matched, else IDLE. req is ignored outside IDLE.
- FSM COMMIT (1 cycle): active_idx <= matched i; active_valid <= 1; save_pulse = 1 this cycle only; flash_cnt <= FLASH_FRAMES. Next state is IDLE. Re-committing the same point is legal: pulse again and restart the flash.
- Total from req cycle to save_pulse is NUM_SAVES+1 cycles.
- flash_cnt: decrements on frame_tick while > 0 and saturates at 0. When a COMMIT load and a frame_tick coincide, the load wins.
- Pixel pipeline:
  - Stage 0 (combinational): point i covers DrawX in [sx-SPR_W/2, sx-SPR_W/2+SPR_W-1] and DrawY in [sy-SPR_H/2, sy-SPR_H/2+SPR_H-1]. Compute in 11 bits; a negative left/top edge clamps to 0. Lowest index wins on overlap. hit0 = save_exist & any point hit.
  - Stage 1 (registered): rom_addr = (DrawY-top)*SPR_W + (DrawX-left). rom_sel = active_valid & (idx==active_idx) & (flash_cnt==0 | flash_cnt[2]==0). hit1 = hit0. When hit0=0, rom_addr=0 and rom_sel=0.
  - Stage 2 (registered): is_save = hit1; save_data = hit1 ? rom_data : 0.
  - Latency from DrawX/DrawY to is_save/save_data is exactly 2 cycles.
- save_exist low: is_save goes to 0 after 2 cycles and req is suppressed. active_idx/active_valid are retained.

Test Plan:
- Reset mid-SCAN (NUM_SAVES=4; Reset asserted on scan cycle 2) -> no save_pulse; after Reset, active_valid=0 and all outputs 0.
- Kid at (270,420), point0=(270,440), keycode=22 held for 10 cycles -> exactly one save_pulse at req+5; active_idx=0; active_valid=1.
- Kid at (300,440) vs point0 at (270,440) (distance 30), then kid at (311,440) (distance 41) -> first press commits, second press gives no pulse; boundary test with kid at (310,440) (dist2=1600) commits.
- Kid within radius of both point1 and point3 -> active_idx=1.
- DrawX/DrawY swept over point2 at (100,100) with SPR_W=SPR_H=20 -> is_save high for X,Y in 90..109, lagging 2 cycles; rom_addr at (90,90)=0 and at (109,109)=399; outside the box save_data=0.
- Commit, then 30 frame_ticks -> rom_sel for active point follows the flash_cnt[2] blink pattern, then stays 1; a point at sx=5 clamps its left edge to 0 with no wrap.
